// File: rtl/icache_comp_pkg.sv
// Shared types and constants for the compressed instruction-cache line decompressor.
package icache_comp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAT,
        FETCH,
        DECODE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_TOKEN,
        PH_RAW_LO,
        PH_RAW_HI
    } phase_t;

    localparam int TOK_RAW_BIT = 15;
    localparam int TOK_IDX_LSB = 0;

    localparam logic [31:0] DEF_LAT_BASE = 32'h0001_0000;

endpackage

// File: rtl/comp_dict_ram.sv
// Decompression dictionary: one synchronous write port, one combinational read port.
// A read of the entry being written in the same cycle returns the old contents.
module comp_dict_ram #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [31:0]          rdata
);

    logic [31:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/icache_line_decomp.sv
// Refills one I-cache line by walking a line address table and decoding 16-bit tokens.
// Optional LAST_LINE_BUF_EN: replays the last completed line without touching memory.
//
// state  | meaning
// IDLE   | wait for a fill request, capture its address
// LAT    | read the line address table entry -> fetch pointer
// FETCH  | read one compressed word at the fetch pointer
// DECODE | consume one halfword per cycle, low half first
// DONE   | one-cycle line_req_ready pulse with the finished line
module icache_line_decomp
    import icache_comp_pkg::*;
#(
    parameter int          NUM_BLOCKS = 4,
    parameter int          BLOCK_SIZE = 4,
    parameter int          DICT_BITS  = 4,
    parameter logic [31:0] LAT_BASE   = DEF_LAT_BASE
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                line_req_valid,
    output logic                                line_req_ready,
    input  logic [31:0]                         line_req_addr,
    output logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0]  line_rdata,
    output logic                                dmem_valid,
    input  logic                                dmem_ready,
    output logic [31:0]                         dmem_addr,
    input  logic [31:0]                         dmem_rdata,
    input  logic                                dict_we,
    input  logic [DICT_BITS-1:0]                dict_waddr,
    input  logic [31:0]                         dict_wdata
);

    localparam int LINE_W   = 8*BLOCK_SIZE*NUM_BLOCKS;
    localparam int OFF_BITS = $clog2(NUM_BLOCKS*BLOCK_SIZE);
    localparam int SLOT_W   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_BLOCKS-1);

    state_t              state, state_n;
    phase_t              phase;
    logic                hw;
    logic [31:0]         req_addr, ptr, word_buf, lat_addr, slot_val, dict_rdata;
    logic [15:0]         half, raw_lo;
    logic [SLOT_W-1:0]   slot_idx;
    logic [LINE_W-1:0]   slot_buf, slot_buf_n;
    logic                slot_wr, lbuf_hit, fill_done;

    comp_dict_ram #(.ADDR_BITS(DICT_BITS)) u_dict (
        .clk   (clk),
        .we    (dict_we),
        .waddr (dict_waddr),
        .wdata (dict_wdata),
        .raddr (half[TOK_IDX_LSB +: DICT_BITS]),
        .rdata (dict_rdata)
    );

    assign half      = hw ? word_buf[31:16] : word_buf[15:0];
    assign lat_addr  = LAT_BASE + ((req_addr >> OFF_BITS) << 2);
    assign fill_done = (state == DECODE) && (state_n == DONE);

`ifdef LAST_LINE_BUF_EN
    logic        lbuf_valid;
    logic [31:0] lbuf_addr;

    assign lbuf_hit = lbuf_valid && (line_req_addr == lbuf_addr);

    // line_rdata itself holds the retained line; only the tag lives here
    always_ff @(posedge clk) begin
        if (!resetn || dict_we) begin
            lbuf_valid <= 1'b0;
        end else if (fill_done) begin
            lbuf_valid <= 1'b1;
            lbuf_addr  <= req_addr;
        end
    end
`else
    assign lbuf_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n        = state;
        dmem_valid     = 1'b0;
        dmem_addr      = '0;
        line_req_ready = 1'b0;
        slot_wr        = 1'b0;
        slot_val       = dict_rdata;
        case (state)
            IDLE: begin
                if (line_req_valid) state_n = lbuf_hit ? DONE : LAT;
            end
            LAT: begin
                dmem_valid = 1'b1;
                dmem_addr  = lat_addr;
                if (dmem_ready) state_n = line_req_valid ? FETCH : IDLE;
            end
            FETCH: begin
                dmem_valid = 1'b1;
                dmem_addr  = ptr;
                if (dmem_ready) state_n = line_req_valid ? DECODE : IDLE;
            end
            DECODE: begin
                if (!line_req_valid) begin
                    state_n = IDLE;
                end else begin
                    if (phase == PH_TOKEN && half[TOK_RAW_BIT]) slot_wr = 1'b1;
                    if (phase == PH_RAW_HI) begin
                        slot_wr  = 1'b1;
                        slot_val = {half, raw_lo};
                    end
                    if (slot_wr && slot_idx == LAST_SLOT) state_n = DONE;
                    else if (hw)                          state_n = FETCH;
                end
            end
            DONE: begin
                line_req_ready = 1'b1;
                state_n        = IDLE;
            end
            default: state_n = IDLE;
        endcase

        slot_buf_n = slot_buf;
        if (slot_wr) slot_buf_n[32*slot_idx +: 32] = slot_val;
    end

    always_ff @(posedge clk) begin
        slot_buf <= slot_buf_n;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            line_rdata <= '0;
            req_addr   <= '0;
            ptr        <= '0;
            word_buf   <= '0;
            raw_lo     <= '0;
            hw         <= 1'b0;
            phase      <= PH_TOKEN;
            slot_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_req_valid) begin
                        req_addr <= line_req_addr;
                        slot_idx <= '0;
                        phase    <= PH_TOKEN;
                        hw       <= 1'b0;
                    end
                end
                LAT: begin
                    if (dmem_ready) ptr <= {dmem_rdata[31:2], 2'b00};
                end
                FETCH: begin
                    if (dmem_ready) begin
                        word_buf <= dmem_rdata;
                        ptr      <= ptr + 32'd4;
                        hw       <= 1'b0;
                    end
                end
                DECODE: begin
                    if (line_req_valid) begin
                        hw <= ~hw;
                        if (slot_wr) slot_idx <= slot_idx + SLOT_W'(1);
                        // a raw slot spans the next two halfwords, possibly across a fetch
                        case (phase)
                            PH_TOKEN:  if (!half[TOK_RAW_BIT]) phase <= PH_RAW_LO;
                            PH_RAW_LO: begin
                                raw_lo <= half;
                                phase  <= PH_RAW_HI;
                            end
                            default:   phase <= PH_TOKEN;
                        endcase
                    end
                end
                default: ;
            endcase
            if (fill_done) line_rdata <= slot_buf_n;
        end
    end

endmodule

// File: tb/tb_icache_line_decomp.sv
// Directed scoreboard bench for icache_line_decomp: expected lines are queued at request
// time and compared by an independent monitor whenever line_req_ready pulses.
module tb_icache_line_decomp;

    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          line_req_valid = 1'b0;
    logic          line_req_ready;
    logic [31:0]   line_req_addr = '0;
    logic [LW-1:0] line_rdata;
    logic          dmem_valid;
    logic          dmem_ready;
    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_rdata;
    logic          dict_we = 1'b0;
    logic [3:0]    dict_waddr = '0;
    logic [31:0]   dict_wdata = '0;

    int total = 0;
    int bad = 0;
    int xfer_cnt = 0;
    int ready_cnt = 0;
    int wait_cfg = 0;
    int wait_cnt = 0;
    logic [LW-1:0] exp_q[$];

    icache_line_decomp dut (
        .clk            (clk),
        .resetn         (resetn),
        .line_req_valid (line_req_valid),
        .line_req_ready (line_req_ready),
        .line_req_addr  (line_req_addr),
        .line_rdata     (line_rdata),
        .dmem_valid     (dmem_valid),
        .dmem_ready     (dmem_ready),
        .dmem_addr      (dmem_addr),
        .dmem_rdata     (dmem_rdata),
        .dict_we        (dict_we),
        .dict_waddr     (dict_waddr),
        .dict_wdata     (dict_wdata)
    );

    always #5 clk = ~clk;

    // LAT entries: lines 1 and 6 point at the raw-token stream (low bits set to test masking)
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] d;
        if (a == 32'h0001_0004)                            d = 32'h0000_0303;
        else if (a == 32'h0001_0018)                       d = 32'h0000_0301;
        else if (a >= 32'h0001_0000 && a < 32'h0001_0040) d = 32'h0000_0200;
        else begin
            case (a)
                32'h0000_0200, 32'h0000_0204: d = 32'h8003_8003;
                32'h0000_0300:                d = 32'h1234_0000;
                32'h0000_0304:                d = 32'h8001_ABCD;
                32'h0000_0308:                d = 32'h8001_8002;
                default:                      d = 32'hDEAD_BEEF;
            endcase
        end
        return d;
    endfunction

    assign dmem_rdata = mem_rd(dmem_addr);
    assign dmem_ready = dmem_valid && (wait_cnt >= wait_cfg);

    always @(posedge clk) begin
        if (dmem_valid && !dmem_ready) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    logic        pend = 1'b0;
    logic [31:0] first_addr = '0;
    int          waited = 0;

    always @(negedge clk) begin
        if (dmem_valid) begin
            if (!pend) begin
                pend       = 1'b1;
                first_addr = dmem_addr;
                waited     = 0;
            end
            if (dmem_ready) begin
                xfer_cnt++;
                if (waited > 0) check("dmem_addr_stable", dmem_addr, first_addr);
                pend = 1'b0;
            end else begin
                waited++;
            end
        end else begin
            pend = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [LW-1:0] e;
        if (resetn && line_req_ready) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got pulse data %0h, want no pulse", line_rdata);
            end else begin
                e = exp_q.pop_front();
                check("line_rdata", line_rdata, e);
            end
        end
    end

    task automatic dict_write(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        dict_we    = 1'b1;
        dict_waddr = idx;
        dict_wdata = data;
        @(negedge clk);
        dict_we = 1'b0;
    endtask

    // cycle count: the negedge inside cycle k after the sampling edge reads k
    task automatic do_fill(input logic [31:0] addr, input logic [LW-1:0] exp,
                           input int exp_cyc, input int exp_xfers);
        int cyc;
        int x0;
        bit seen;
        logic [LW-1:0] dummy;
        exp_q.push_back(exp);
        @(negedge clk);
        x0             = xfer_cnt;
        line_req_valid = 1'b1;
        line_req_addr  = addr;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (line_req_ready) seen = 1'b1;
        end
        line_req_valid = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL fill_timeout: got no ready in %0d cycles for addr %0h, want ready", cyc, addr);
            dummy = exp_q.pop_back();
        end else begin
            if (exp_cyc >= 0)   check("ready_cycle", LW'(cyc), LW'(exp_cyc));
            if (exp_xfers >= 0) check("dmem_xfers", LW'(xfer_cnt - x0), LW'(exp_xfers));
            @(negedge clk);
            check("ready_single_pulse", LW'(line_req_ready), '0);
        end
    endtask

    task automatic wait_fetch(output bit found);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (dmem_valid && dmem_addr == 32'h0000_0200) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: got no FETCH read of 200, want one");
        end
    endtask

    initial begin
        logic [LW-1:0] line_a, line_b, line_c, line_d;
        int  x0;
        int  r0;
        bit  found;

        line_a = {4{32'h0000_0013}};
        line_b = {32'h1111_0001, 32'h2222_0002, 32'h1111_0001, 32'hABCD_1234};
        line_c = {32'h0000_0077, 32'h0000_0077, 32'h0000_0077, 32'h0000_0013};
        line_d = {4{32'h0000_0077}};

        repeat (3) @(negedge clk);
        check("rst_ready", LW'(line_req_ready), '0);
        check("rst_dmem_valid", LW'(dmem_valid), '0);
        check("rst_dmem_addr", LW'(dmem_addr), '0);
        check("rst_line_rdata", line_rdata, '0);
        resetn = 1'b1;

        dict_write(4'd1, 32'h1111_0001);
        dict_write(4'd2, 32'h2222_0002);
        dict_write(4'd3, 32'h0000_0013);

        do_fill(32'h0000_0000, line_a, 8, 3);
        do_fill(32'h0000_0010, line_b, 11, 4);

        wait_cfg = 3;
        do_fill(32'h0000_0030, line_a, -1, 3);
        wait_cfg = 0;

        wait_cfg = 2;
        @(negedge clk);
        line_req_valid = 1'b1;
        line_req_addr  = 32'h0000_0050;
        wait_fetch(found);
        line_req_valid = 1'b0;
        x0 = xfer_cnt;
        r0 = ready_cnt;
        repeat (10) @(negedge clk);
        check("abort_read_completes", LW'(xfer_cnt - x0), LW'(1));
        check("abort_no_ready", LW'(ready_cnt - r0), '0);
        check("abort_idle", LW'(dmem_valid), '0);
        wait_cfg = 0;
        do_fill(32'h0000_0060, line_b, 11, 4);

        fork
            do_fill(32'h0000_0070, line_c, 8, 3);
            begin
                repeat (4) @(negedge clk);
                dict_we    = 1'b1;
                dict_waddr = 4'd3;
                dict_wdata = 32'h0000_0077;
                @(negedge clk);
                dict_we = 1'b0;
            end
        join
        do_fill(32'h0000_0080, line_d, 8, 3);

        do_fill(32'h0000_0040, line_d, 8, 3);
`ifdef LAST_LINE_BUF_EN
        do_fill(32'h0000_0040, line_d, 1, 0);
`else
        do_fill(32'h0000_0040, line_d, 8, 3);
`endif
        dict_write(4'd5, 32'h5555_0005);
        do_fill(32'h0000_0040, line_d, 8, 3);

        wait_cfg = 2;
        @(negedge clk);
        line_req_valid = 1'b1;
        line_req_addr  = 32'h0000_0090;
        wait_fetch(found);
        resetn         = 1'b0;
        line_req_valid = 1'b0;
        @(negedge clk);
        check("midfill_rst_dmem_valid", LW'(dmem_valid), '0);
        check("midfill_rst_ready", LW'(line_req_ready), '0);
        check("midfill_rst_line_rdata", line_rdata, '0);
        @(negedge clk);
        resetn   = 1'b1;
        wait_cfg = 0;
        do_fill(32'h0000_00A0, line_d, 8, 3);

        check("scoreboard_drained", LW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
